// File: rtl/pwm_gen_pkg.sv
// ---------------------------------------------------------------------------
// pwm_gen_pkg
//   Shared constants for the oscillator mixer PWM output stage.
//   OSC_VOICES   number of oscillator voices feeding the mixer
//   OSC_CNT_BW   width needed to hold a voice count 0..OSC_VOICES
//   PWM_BW_DEF   default PWM counter width (max period 2**PWM_BW_DEF-1)
//   popcount()   number of set bits in a 32-bit word
// ---------------------------------------------------------------------------
package pwm_gen_pkg;

    localparam int OSC_VOICES = 7;
    localparam int OSC_CNT_BW = $clog2(OSC_VOICES + 1);
    localparam int PWM_BW_DEF = 3;

    function automatic int unsigned popcount(input logic [31:0] w);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, w[i]};
        end
        return n;
    endfunction

endpackage : pwm_gen_pkg

// File: rtl/pwm_gen_if.sv
// ---------------------------------------------------------------------------
// pwm_gen_if
//   Bundles the duty-cycle request and the PWM stream of one generator.
//   onCnt_i      high cycles per period (duty numerator)
//   periodCnt_i  period length in clock cycles (duty denominator)
//   pwm_o        registered PWM stream
//   master : the integrator side (drives the duty request, reads the stream)
//   slave  : the generator side
//   There is no handshake: the request is level-sampled by the generator
//   only at period boundaries, so the master may change it at any time.
// ---------------------------------------------------------------------------
interface pwm_gen_if
    import pwm_gen_pkg::*;
#(
    parameter int PWM_BW = PWM_BW_DEF
) ();

    logic [PWM_BW-1:0] onCnt_i;
    logic [PWM_BW-1:0] periodCnt_i;
    logic              pwm_o;

    modport master (
        output onCnt_i,
        output periodCnt_i,
        input  pwm_o
    );

    modport slave (
        input  onCnt_i,
        input  periodCnt_i,
        output pwm_o
    );

endinterface : pwm_gen_if

// File: rtl/pwm_gen_bitcount.sv
// ---------------------------------------------------------------------------
// pwm_gen_bitcount
//   Purely combinational popcount; normally turns the voice-active mask into
//   the PWM duty numerator.
//   word_i   [WORDLEN-1:0]            input word
//   count_o  [$clog2(WORDLEN+1)-1:0]  number of 1 bits in word_i
//   WORDLEN must not exceed 32.
// ---------------------------------------------------------------------------
module pwm_gen_bitcount
    import pwm_gen_pkg::*;
#(
    parameter int WORDLEN = OSC_VOICES
) (
    input  logic [WORDLEN-1:0]             word_i,
    output logic [$clog2(WORDLEN+1)-1:0]   count_o
);

    localparam int CW = $clog2(WORDLEN + 1);

    always_comb begin
        count_o = CW'(popcount(32'(word_i)));
    end

endmodule : pwm_gen_bitcount

// File: rtl/pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
//   Counter-based PWM generator. Emits a 1-bit stream that is high for
//   min(on,period) cycles at the start of every period of `period` cycles.
//   clk_i    single system clock, rising edge
//   nrst_i   synchronous active-low reset
//   pwm_bus  pwm_gen_if.slave: onCnt_i, periodCnt_i in; pwm_o out
//
//   The duty request is copied into shadow registers only when the counter
//   wraps, so mid-period changes never truncate or glitch a period. The
//   output is registered from the counter state: no combinational path from
//   the request inputs to pwm_o. A zero period keeps the output low and
//   retries the shadow load on every cycle.
// ---------------------------------------------------------------------------
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int PWM_BW = PWM_BW_DEF
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    pwm_gen_if.slave     pwm_bus
);

    localparam logic [PWM_BW-1:0] ONE  = PWM_BW'(1);
    localparam logic [PWM_BW-1:0] ZERO = '0;

    logic [PWM_BW-1:0] r_cnt;
    logic [PWM_BW-1:0] r_on;
    logic [PWM_BW-1:0] r_per;
    logic              r_pwm;
    logic              w_wrap;

    // r_per-1 underflows when r_per==0; the first term covers that case.
    always_comb begin
        w_wrap = (r_per == ZERO) || (r_cnt >= (r_per - ONE));
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            r_cnt <= ZERO;
            r_on  <= ZERO;
            r_per <= ZERO;
            r_pwm <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt <= ZERO;
                r_on  <= pwm_bus.onCnt_i;
                r_per <= pwm_bus.periodCnt_i;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
            r_pwm <= (r_per != ZERO) && (r_cnt < r_on);
        end
    end

    assign pwm_bus.pwm_o = r_pwm;

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_gen
//   Bench for pwm_gen: a popcount of a 7-bit voice mask drives onCnt_i,
//   periodCnt_i is driven directly. Expected output streams are written as
//   strings of '0'/'1', one character per clock edge, sampled 1 time unit
//   after each rising edge.
// ---------------------------------------------------------------------------
module tb_pwm_gen;
    import pwm_gen_pkg::*;

    localparam int BW = 3;

    // clock / reset
    logic clk;
    logic nrst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus and wiring
    logic [OSC_VOICES-1:0] active_oscs;
    logic [BW-1:0]         period_cnt;
    logic [OSC_CNT_BW-1:0] w_on_cnt;

    pwm_gen_if #(.PWM_BW(BW)) pwm_bus ();

    pwm_gen_bitcount #(.WORDLEN(OSC_VOICES)) u_bitcount (
        .word_i  (active_oscs),
        .count_o (w_on_cnt)
    );

    assign pwm_bus.onCnt_i     = w_on_cnt;
    assign pwm_bus.periodCnt_i = period_cnt;

    pwm_gen #(.PWM_BW(BW)) dut (
        .clk_i   (clk),
        .nrst_i  (nrst),
        .pwm_bus (pwm_bus)
    );

    // checking
    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge per pattern character and compare pwm_o with it.
    task automatic run_pattern(input string tag, input string pat);
        logic exp_bit;
        for (int i = 0; i < pat.len(); i++) begin
            @(posedge clk);
            #1;
            exp_bit = (pat.getc(i) == "1");
            check_eq($sformatf("%s[%0d]", tag, i), {31'b0, pwm_bus.pwm_o}, {31'b0, exp_bit});
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        nrst        = 1'b0;
        active_oscs = 7'b0000111;
        period_cnt  = 3'd7;

        // 1. reset held for 5 edges: output stays low
        run_pattern("reset", "00000");

        // 2. on=3 of 7: one shadow-load edge, then 3 high / 4 low repeating
        nrst = 1'b1;
        run_pattern("duty3of7", "0111000011100001110000");

        // 3a. on=0: current period finishes, then constant low
        active_oscs = 7'b0000000;
        run_pattern("duty0", "111000000000000000000");

        // 3b. on=7: current (zero) period finishes, then constant high
        active_oscs = 7'h7F;
        run_pattern("duty7", "000000011111111111111");

        // 4. on=1, then switch to on=5 mid-period
        active_oscs = 7'b0000001;
        run_pattern("duty1_load", "1111111");
        run_pattern("duty1_head", "10");
        active_oscs = 7'b0011111;
        run_pattern("duty1_tail", "00000");
        run_pattern("duty5of7", "11111001111100");

        // 5. period 0 -> constant low; then period 4, on 2 -> 2 high / 2 low
        period_cnt  = 3'd0;
        active_oscs = 7'b0000011;
        run_pattern("per0_drain", "1111100");
        run_pattern("per0", "00000");
        period_cnt = 3'd4;
        run_pattern("duty2of4", "0110011001100");

        // 6. reset mid-period, then restart with one shadow-load edge
        run_pattern("pre_reset", "11");
        nrst = 1'b0;
        run_pattern("mid_reset", "00");
        nrst = 1'b1;
        run_pattern("restart", "011001100");

        // 7. period 1: high iff on>=1
        period_cnt  = 3'd1;
        active_oscs = 7'b0000001;
        run_pattern("per1_on1", "110011111");
        active_oscs = 7'b0000000;
        run_pattern("per1_on0", "1000");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pwm_gen
